// File: rtl/evt_window_ctrl_pkg.sv
// Shared types and defaults for the event-window sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package evt_window_pkg;

  localparam int WIN_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  // Saturated value of a default-width counter; the next event wraps it.
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    COUNT  = 2'd2,
    SETTLE = 2'd3
  } state_t;

endpackage

// File: rtl/evt_window_ctrl_if.sv
// Control/counter bundle between the window sequencer and its surroundings.
// Latency: n/a (wires only). Optional auto_in present with EVT_WINDOW_AUTO_RESTART_EN.
// Backpressure: none; start_in is simply ignored while the sequencer is busy.
interface evt_window_ctrl_if #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
);

`ifdef EVT_WINDOW_AUTO_RESTART_EN
  logic             auto_in;
`endif
  logic             start_in;
  logic             abort_in;
  logic [WIN_W-1:0] win_len_in;
  logic             evt_in;
  logic [CNT_W-1:0] cnt_val_in;
  logic             cnt_clr_out;
  logic             cnt_evt_out;
  logic             busy_out;
  logic             done_out;
  logic [CNT_W-1:0] result_out;
  logic             ovf_out;

  // Sequencer side.
  modport slave (
`ifdef EVT_WINDOW_AUTO_RESTART_EN
    input  auto_in,
`endif
    input  start_in,
    input  abort_in,
    input  win_len_in,
    input  evt_in,
    input  cnt_val_in,
    output cnt_clr_out,
    output cnt_evt_out,
    output busy_out,
    output done_out,
    output result_out,
    output ovf_out
  );

  // Control logic / counter datapath side.
  modport master (
`ifdef EVT_WINDOW_AUTO_RESTART_EN
    output auto_in,
`endif
    output start_in,
    output abort_in,
    output win_len_in,
    output evt_in,
    output cnt_val_in,
    input  cnt_clr_out,
    input  cnt_evt_out,
    input  busy_out,
    input  done_out,
    input  result_out,
    input  ovf_out
  );

endinterface

// File: rtl/evt_window_ctrl_window_timer.sv
// Loadable down-counter that measures the gating window; a zero length loads as one.
// Latency: o_last is combinational from the timer register (high while timer==1).
// Backpressure: none; i_load has priority over i_en.
module window_timer
  import evt_window_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIN_W-1:0] i_len,
  input  logic             i_en,
  output logic             o_last
);

  logic [WIN_W-1:0] r_timer;
  logic [WIN_W-1:0] w_len_eff;

  assign w_len_eff = (i_len == '0) ? WIN_W'(1) : i_len;

  // Load on window start, count down once per gating cycle, park at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (i_load) begin
      r_timer <= w_len_eff;
    end else if (i_en && (r_timer != '0)) begin
      r_timer <= r_timer - WIN_W'(1);
    end
  end

  assign o_last = (r_timer == WIN_W'(1));

endmodule

// File: rtl/evt_window_ctrl.sv
// Clears an external event counter, gates events into it for N cycles, captures the count.
// Latency: start sampled at edge E0 -> done_out high in the cycle after edge E0+N+2.
// Backpressure: start_in ignored while busy; abort_in drops the window. Macro: EVT_WINDOW_AUTO_RESTART_EN.
module evt_window_ctrl
  import evt_window_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  evt_window_ctrl_if.slave   bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_timer_load;
  logic             w_timer_last;
  logic             w_auto;
  logic             w_cnt_clr;
  logic             w_cnt_evt;
  logic             w_abort;
  logic             w_settle_ok;
  logic             w_wrap;
  logic             r_sticky;
  logic             r_done;
  logic             r_ovf;
  logic [CNT_W-1:0] r_result;

`ifdef EVT_WINDOW_AUTO_RESTART_EN
  assign w_auto = bus.auto_in;
`else
  assign w_auto = 1'b0;
`endif

  // Abort only has meaning once a window is in flight; in IDLE a start wins.
  assign w_abort     = (r_state != IDLE) && bus.abort_in;
  assign w_settle_ok = (r_state == SETTLE) && !bus.abort_in;
  // An event accepted while the counter already holds all-ones wraps it.
  assign w_wrap      = w_cnt_evt && (&bus.cnt_val_in);

  window_timer #(
    .WIN_W (WIN_W)
  ) u_window_timer (
    .i_clk  (clk_in),
    .i_rst  (rst_in),
    .i_load (w_timer_load),
    .i_len  (bus.win_len_in),
    .i_en   (r_state == COUNT),
    .o_last (w_timer_last)
  );

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, timer load and the counter strobes, which depend on state only.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_load = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_evt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_in) begin
          w_state_nxt  = CLEAR;
          w_timer_load = 1'b1;
        end
      end
      CLEAR: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = COUNT;
      end
      COUNT: begin
        w_cnt_evt = bus.evt_in;
        if (w_timer_last) begin
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (w_auto) begin
          w_state_nxt  = CLEAR;
          w_timer_load = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_nxt  = IDLE;
      w_timer_load = 1'b0;
    end
  end

  // Overflow sticky: cleared with the counter, set by any wrap during gating.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sticky <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_sticky <= 1'b0;
    end else if (w_wrap) begin
      r_sticky <= 1'b1;
    end
  end

  // Capture result and overflow in SETTLE, when the last gated event is visible.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= w_settle_ok;
      if (w_settle_ok) begin
        r_result <= bus.cnt_val_in;
        r_ovf    <= r_sticky;
      end
    end
  end

  assign bus.cnt_clr_out = w_cnt_clr;
  assign bus.cnt_evt_out = w_cnt_evt;
  assign bus.busy_out    = (r_state != IDLE);
  assign bus.done_out    = r_done;
  assign bus.result_out  = r_result;
  assign bus.ovf_out     = r_ovf;

endmodule

// File: tb/tb_evt_window_ctrl.sv
// Bench for evt_window_ctrl: table of windows, random windows vs. an arithmetic model,
// and hand sequences for abort, back-to-back start, async reset and auto-restart.
// Optional auto-restart section built with EVT_WINDOW_AUTO_RESTART_EN.
module tb_evt_window_ctrl;
  import evt_window_pkg::*;

  localparam int WIN_W = 16;
  localparam int CNT_W = 16;

  logic clk_in = 1'b0;
  logic rst_in;

  evt_window_ctrl_if #(.WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();

  evt_window_ctrl #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // External counter: clear loads pre_val (0 normally, a preload for wrap tests).
  logic [CNT_W-1:0] ext_cnt;
  logic [CNT_W-1:0] pre_val;
  assign bus.cnt_val_in = ext_cnt;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                ext_cnt <= '0;
    else if (bus.cnt_clr_out)  ext_cnt <= pre_val;
    else if (bus.cnt_evt_out)  ext_cnt <= ext_cnt + 1'b1;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // mode 0: no events, 1: every cycle, 2: even cycles only, 3: random
  function automatic logic evt_at(input int mode, input int k);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((k % 2) == 0);
      default: return ($urandom_range(0, 1) != 0);
    endcase
  endfunction

  // Runs one window starting at the current negedge (DUT idle or in its done cycle).
  // Cycle k is the k-th cycle after the start edge: k=1 clear, k=2..N+1 gated.
  task automatic run_window(input int win, input int mode, input int pre,
                            output int res, output int ovf, output int lat,
                            output int n_gated);
    int  n_eff;
    logic e;
    n_eff   = (win == 0) ? 1 : win;
    n_gated = 0;
    lat     = -1;
    res     = -1;
    ovf     = -1;
    pre_val        = pre[CNT_W-1:0];
    bus.win_len_in = win[WIN_W-1:0];
    bus.start_in   = 1'b1;
    bus.evt_in     = evt_at(mode, 0);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk_in);
      if (bus.done_out) begin
        lat        = k - 1;
        res        = int'(bus.result_out);
        ovf        = int'(bus.ovf_out);
        bus.evt_in = 1'b0;
        break;
      end
      if (k == 1) chk("clear_pulse", int'(bus.cnt_clr_out), 1);
      bus.start_in = 1'b0;
      e            = evt_at(mode, k);
      bus.evt_in   = e;
      if (k >= 2 && k <= n_eff + 1 && e) n_gated++;
    end
  endtask

  typedef struct {
    int win;
    int mode;
    int pre;
    int exp_res;
    int exp_ovf;
    int exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int res, ovf, lat, ng, n_eff, sum, exp_res, exp_ovf;
    int last_res, last_ovf, seen, dones, first_k, second_k;

    vecs[0] = '{10, 1, 0,             10, 0, 12};
    vecs[1] = '{0,  1, 0,             1,  0, 3};
    vecs[2] = '{4,  1, 65534,         2,  1, 6};
    vecs[3] = '{8,  2, 0,             4,  0, 10};
    vecs[4] = '{3,  0, 0,             0,  0, 5};
    vecs[5] = '{2,  1, int'(CNT_MAX), 1,  1, 4};

    rst_in         = 1'b1;
    bus.start_in   = 1'b0;
    bus.abort_in   = 1'b0;
    bus.win_len_in = '0;
    bus.evt_in     = 1'b1;
    pre_val        = '0;
`ifdef EVT_WINDOW_AUTO_RESTART_EN
    bus.auto_in    = 1'b0;
`endif
    repeat (2) @(negedge clk_in);
    chk("rst_busy",   int'(bus.busy_out),    0);
    chk("rst_done",   int'(bus.done_out),    0);
    chk("rst_result", int'(bus.result_out),  0);
    chk("rst_ovf",    int'(bus.ovf_out),     0);
    chk("rst_evt",    int'(bus.cnt_evt_out), 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("idle_evt_gated", int'(bus.cnt_evt_out), 0);
    chk("idle_no_clr",    int'(bus.cnt_clr_out), 0);
    bus.evt_in = 1'b0;

    // Table-driven windows, applied back to back.
    for (int i = 0; i < 6; i++) begin
      run_window(vecs[i].win, vecs[i].mode, vecs[i].pre, res, ovf, lat, ng);
      chk($sformatf("tab%0d_result", i),  res, vecs[i].exp_res);
      chk($sformatf("tab%0d_ovf", i),     ovf, vecs[i].exp_ovf);
      chk($sformatf("tab%0d_latency", i), lat, vecs[i].exp_lat);
    end

    // Random windows against the arithmetic model: result = (pre + gated events) mod 2^16.
    for (int i = 0; i < 20; i++) begin
      int w, p;
      w = $urandom_range(0, 12);
      if ($urandom_range(0, 2) == 0) p = 65536 - $urandom_range(1, 8);
      else                           p = $urandom_range(0, 1000);
      run_window(w, 3, p, res, ovf, lat, ng);
      n_eff   = (w == 0) ? 1 : w;
      sum     = p + ng;
      exp_res = sum % 65536;
      exp_ovf = (sum > 65535) ? 1 : 0;
      chk($sformatf("rnd%0d_result", i),  res, exp_res);
      chk($sformatf("rnd%0d_ovf", i),     ovf, exp_ovf);
      chk($sformatf("rnd%0d_latency", i), lat, n_eff + 2);
      last_res = exp_res;
      last_ovf = exp_ovf;
    end
    pre_val = '0;

    // Abort on the third gated cycle: idle next edge, no done, previous result kept.
    bus.win_len_in = 16'd10;
    bus.start_in   = 1'b1;
    bus.evt_in     = 1'b1;
    @(negedge clk_in);
    bus.start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("abort_in_count", int'(bus.cnt_evt_out), 1);
    bus.abort_in = 1'b1;
    @(negedge clk_in);
    bus.abort_in = 1'b0;
    chk("abort_idle",  int'(bus.busy_out),    0);
    chk("abort_gated", int'(bus.cnt_evt_out), 0);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_in);
      if (bus.done_out) seen++;
    end
    chk("abort_no_done", seen,                   0);
    chk("abort_result",  int'(bus.result_out),   last_res);
    chk("abort_ovf",     int'(bus.ovf_out),      last_ovf);

    // Start and abort together in idle: start wins; abort in CLEAR then drops it.
    bus.start_in = 1'b1;
    bus.abort_in = 1'b1;
    @(negedge clk_in);
    bus.start_in = 1'b0;
    chk("start_wins_busy", int'(bus.busy_out),    1);
    chk("start_wins_clr",  int'(bus.cnt_clr_out), 1);
    @(negedge clk_in);
    bus.abort_in = 1'b0;
    chk("abort_clear_idle", int'(bus.busy_out), 0);
    @(negedge clk_in);
    chk("abort_clear_nodone", int'(bus.done_out), 0);

    // Start while busy is ignored; start in the done cycle gives a back-to-back window.
    bus.win_len_in = 16'd3;
    bus.start_in   = 1'b1;
    bus.evt_in     = 1'b1;
    dones = 0; first_k = -1; second_k = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_in);
      if (first_k > 0 && k == first_k + 1) chk("b2b_clear", int'(bus.cnt_clr_out), 1);
      if (bus.done_out) begin
        dones++;
        if (dones == 1)      first_k  = k;
        else if (dones == 2) second_k = k;
        chk("b2b_result", int'(bus.result_out), 3);
      end
      bus.start_in = (k == 3) || (bus.done_out && dones == 1);
    end
    bus.start_in = 1'b0;
    chk("b2b_windows", dones,    2);
    chk("b2b_first",   first_k,  6);
    chk("b2b_second",  second_k, 12);

    // Asynchronous reset between edges in the middle of gating.
    bus.win_len_in = 16'd10;
    bus.start_in   = 1'b1;
    @(negedge clk_in);
    bus.start_in = 1'b0;
    repeat (2) @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_busy",   int'(bus.busy_out),    0);
    chk("arst_done",   int'(bus.done_out),    0);
    chk("arst_result", int'(bus.result_out),  0);
    chk("arst_ovf",    int'(bus.ovf_out),     0);
    chk("arst_evt",    int'(bus.cnt_evt_out), 0);
    chk("arst_clr",    int'(bus.cnt_clr_out), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    run_window(5, 1, 0, res, ovf, lat, ng);
    chk("post_rst_result",  res, 5);
    chk("post_rst_latency", lat, 7);

`ifdef EVT_WINDOW_AUTO_RESTART_EN
    // Auto restart: a done pulse every N+2 cycles until aborted.
    bus.auto_in    = 1'b1;
    bus.win_len_in = 16'd5;
    bus.start_in   = 1'b1;
    bus.evt_in     = 1'b1;
    dones = 0; first_k = -1; second_k = -1;
    for (int k = 1; k <= 40 && dones < 3; k++) begin
      @(negedge clk_in);
      bus.start_in = 1'b0;
      if (bus.done_out) begin
        dones++;
        chk("auto_result", int'(bus.result_out), 5);
        if (dones == 1)      first_k = k;
        else if (dones == 2) begin chk("auto_period1", k - first_k, 7); second_k = k; end
        else                 chk("auto_period2", k - second_k, 7);
      end
    end
    chk("auto_dones", dones, 3);
    bus.abort_in = 1'b1;
    @(negedge clk_in);
    bus.abort_in = 1'b0;
    bus.auto_in  = 1'b0;
    chk("auto_abort_idle", int'(bus.busy_out), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
